// File: rtl/alsu_gen_pkg.sv
// ============================================================================
// Module   : alsu_gen_pkg
// Purpose  : Opcode encoding and invalid-operation decode shared by alsu_gen.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alsu_gen_pkg;

    typedef enum logic [2:0] {
        OR     = 3'd0,
        XOR    = 3'd1,
        ADD    = 3'd2,
        MULT   = 3'd3,
        SHIFT  = 3'd4,
        ROTATE = 3'd5,
        INV6   = 3'd6,
        INV7   = 3'd7
    } opcode_e;

    // Reduction requests are only meaningful for the bitwise opcodes.
    function automatic logic is_invalid(opcode_e op, logic red_a, logic red_b);
        return (op == INV6) || (op == INV7) ||
               ((red_a || red_b) && !(op == OR || op == XOR));
    endfunction

endpackage

`default_nettype wire

// File: rtl/alsu_gen_if.sv
// ============================================================================
// Module   : alsu_gen_if
// Purpose  : Operand/control inputs and result outputs of alsu_gen.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alsu_gen_if #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
);
    localparam int OUT_W = 2 * WIDTH;
    localparam int SH_W  = $clog2(OUT_W);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic             red_op_A;
    logic             red_op_B;
    logic             bypass_A;
    logic             bypass_B;
    logic             direction;
    logic             serial_in;
    logic [SH_W-1:0]  shamt;
    logic             cin;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic [OUT_W-1:0] leds;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, A, B, opcode, red_op_A, red_op_B, bypass_A, bypass_B,
               direction, serial_in, shamt, cin,
        input  out, out_valid, leds, err_cnt
    );

    modport slave (
        input  in_valid, A, B, opcode, red_op_A, red_op_B, bypass_A, bypass_B,
               direction, serial_in, shamt, cin,
        output out, out_valid, leds, err_cnt
    );

endinterface

`default_nettype wire

// File: rtl/alsu_gen_datapath.sv
// ============================================================================
// Module   : alsu_gen_datapath
// Purpose  : Stage-2 next-result logic. ALSU_GEN_FULL_ADDER_EN adds cin to ADD.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alsu_gen_datapath
    import alsu_gen_pkg::*;
#(
    parameter  int WIDTH      = 3,
    parameter  int PRIORITY_A = 1,
    localparam int OUT_W      = 2 * WIDTH,
    localparam int SH_W       = $clog2(OUT_W)
) (
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    input  wire logic [2:0]       opcode_i,
    input  wire logic             red_a_i,
    input  wire logic             red_b_i,
    input  wire logic             bypass_a_i,
    input  wire logic             bypass_b_i,
    input  wire logic             direction_i,
    input  wire logic             serial_in_i,
    input  wire logic [SH_W-1:0]  shamt_i,
    input  wire logic             cin_i,
    input  wire logic [OUT_W-1:0] out_q_i,
    output logic      [OUT_W-1:0] out_d_o,
    output logic                  invalid_o
);

    opcode_e            w_op;
    logic [OUT_W-1:0]   w_a_sx, w_b_sx, w_sum, w_prod, w_fill, w_shift, w_rot;
    logic [WIDTH-1:0]   w_byp_sel, w_red_sel;
    logic [SH_W-1:0]    w_rot_amt;
    logic [2*OUT_W-1:0] w_rot_l, w_rot_r;

    assign w_op   = opcode_e'(opcode_i);
    assign w_a_sx = {{(OUT_W-WIDTH){a_i[WIDTH-1]}}, a_i};
    assign w_b_sx = {{(OUT_W-WIDTH){b_i[WIDTH-1]}}, b_i};

    assign w_byp_sel = (bypass_a_i && (!bypass_b_i || PRIORITY_A != 0)) ? a_i : b_i;
    assign w_red_sel = (red_a_i && (!red_b_i || PRIORITY_A != 0)) ? a_i : b_i;

`ifdef ALSU_GEN_FULL_ADDER_EN
    assign w_sum = w_a_sx + w_b_sx + {{(OUT_W-1){1'b0}}, cin_i};
`else
    logic w_unused_cin;
    assign w_unused_cin = cin_i;
    assign w_sum        = w_a_sx + w_b_sx;
`endif

    assign w_prod = w_a_sx * w_b_sx;

    // Over-range amounts shift everything out and the mask becomes all ones,
    // so shamt >= OUT_W naturally yields a register full of serial_in.
    assign w_fill  = {OUT_W{serial_in_i}};
    assign w_shift = direction_i
                   ? ((out_q_i << shamt_i) | (w_fill & ~({OUT_W{1'b1}} << shamt_i)))
                   : ((out_q_i >> shamt_i) | (w_fill & ~({OUT_W{1'b1}} >> shamt_i)));

    assign w_rot_amt = SH_W'(32'(shamt_i) % OUT_W);
    assign w_rot_l   = {out_q_i, out_q_i} << w_rot_amt;
    assign w_rot_r   = {out_q_i, out_q_i} >> w_rot_amt;
    assign w_rot     = direction_i ? w_rot_l[2*OUT_W-1:OUT_W] : w_rot_r[OUT_W-1:0];

    always_comb begin
        invalid_o = is_invalid(w_op, red_a_i, red_b_i);
        out_d_o   = out_q_i;
        if (invalid_o) begin
            out_d_o = '0;
        end else if (bypass_a_i || bypass_b_i) begin
            out_d_o = {{(OUT_W-WIDTH){1'b0}}, w_byp_sel};
        end else begin
            case (w_op)
                OR:      out_d_o = (red_a_i || red_b_i)
                                 ? {{(OUT_W-1){1'b0}}, |w_red_sel}
                                 : {{(OUT_W-WIDTH){1'b0}}, a_i | b_i};
                XOR:     out_d_o = (red_a_i || red_b_i)
                                 ? {{(OUT_W-1){1'b0}}, ^w_red_sel}
                                 : {{(OUT_W-WIDTH){1'b0}}, a_i ^ b_i};
                ADD:     out_d_o = w_sum;
                MULT:    out_d_o = w_prod;
                SHIFT:   out_d_o = w_shift;
                ROTATE:  out_d_o = w_rot;
                default: out_d_o = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alsu_gen.sv
// ============================================================================
// Module   : alsu_gen
// Purpose  : Two-stage pipelined ALSU; ALSU_GEN_FULL_ADDER_EN enables ADD carry-in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alsu_gen
    import alsu_gen_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int ERR_W      = 8,
    parameter int PRIORITY_A = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alsu_gen_if.slave   bus
);

    localparam int OUT_W = 2 * WIDTH;
    localparam int SH_W  = $clog2(OUT_W);

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       opcode_q;
    logic             red_a_q, red_b_q, byp_a_q, byp_b_q;
    logic             dir_q, si_q, cin_q;
    logic [SH_W-1:0]  shamt_q;

    logic [OUT_W-1:0] out_q, leds_q, out_d;
    logic             out_valid_q, w_invalid;
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            opcode_q   <= '0;
            red_a_q    <= 1'b0;
            red_b_q    <= 1'b0;
            byp_a_q    <= 1'b0;
            byp_b_q    <= 1'b0;
            dir_q      <= 1'b0;
            si_q       <= 1'b0;
            shamt_q    <= '0;
            cin_q      <= 1'b0;
        end else begin
            s1_valid_q <= bus.in_valid;
            a_q        <= bus.A;
            b_q        <= bus.B;
            opcode_q   <= bus.opcode;
            red_a_q    <= bus.red_op_A;
            red_b_q    <= bus.red_op_B;
            byp_a_q    <= bus.bypass_A;
            byp_b_q    <= bus.bypass_B;
            dir_q      <= bus.direction;
            si_q       <= bus.serial_in;
            shamt_q    <= bus.shamt;
            cin_q      <= bus.cin;
        end
    end

    alsu_gen_datapath #(
        .WIDTH      (WIDTH),
        .PRIORITY_A (PRIORITY_A)
    ) u_datapath (
        .a_i         (a_q),
        .b_i         (b_q),
        .opcode_i    (opcode_q),
        .red_a_i     (red_a_q),
        .red_b_i     (red_b_q),
        .bypass_a_i  (byp_a_q),
        .bypass_b_i  (byp_b_q),
        .direction_i (dir_q),
        .serial_in_i (si_q),
        .shamt_i     (shamt_q),
        .cin_i       (cin_q),
        .out_q_i     (out_q),
        .out_d_o     (out_d),
        .invalid_o   (w_invalid)
    );

    // Bubbles hold the result state; only out_valid reflects them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            leds_q      <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_q <= out_d;
                if (w_invalid) begin
                    leds_q <= ~leds_q;
                    if (err_cnt_q != {ERR_W{1'b1}})
                        err_cnt_q <= err_cnt_q + 1'b1;
                end else begin
                    leds_q <= '0;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.leds      = leds_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alsu_gen.sv
// ============================================================================
// Module   : tb_alsu_gen
// Purpose  : Directed and random checks of alsu_gen against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alsu_gen;

    localparam int WIDTH = 3;
    localparam int OUT_W = 6;
    localparam int ERR_W = 8;
    localparam int PRI   = 1;
    localparam int MASK  = (1 << OUT_W) - 1;
    localparam int EMAX  = (1 << ERR_W) - 1;
`ifdef ALSU_GEN_FULL_ADDER_EN
    localparam int FULL  = 1;
`else
    localparam int FULL  = 0;
`endif

    typedef struct {
        bit       v;
        bit [2:0] a, b, op;
        bit       ra, rb, ba, bb, dir, si, cin;
        bit [2:0] sh;
    } tx_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alsu_gen_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bif();

    alsu_gen #(.WIDTH(WIDTH), .ERR_W(ERR_W), .PRIORITY_A(PRI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    tx_t cur, s1;
    int  m_out, m_leds, m_err, m_ov;

    function automatic int sx(bit [2:0] x);
        return x[2] ? int'(x) - 8 : int'(x);
    endfunction

    function automatic tx_t mk(bit v, int op, int a, int b);
        tx_t t;
        t = '{default: 0};
        t.v = v; t.op = 3'(op); t.a = 3'(a); t.b = 3'(b);
        return t;
    endfunction

    function automatic tx_t rnd();
        tx_t t;
        t.v   = ($urandom % 5) != 0;
        t.a   = 3'($urandom);
        t.b   = 3'($urandom);
        t.op  = 3'($urandom);
        t.ra  = ($urandom % 6) == 0;
        t.rb  = ($urandom % 6) == 0;
        t.ba  = ($urandom % 6) == 0;
        t.bb  = ($urandom % 6) == 0;
        t.dir = 1'($urandom);
        t.si  = 1'($urandom);
        t.cin = 1'($urandom);
        t.sh  = 3'($urandom);
        return t;
    endfunction

    task automatic drive(tx_t t);
        cur           = t;
        bif.in_valid  = t.v;
        bif.A         = t.a;
        bif.B         = t.b;
        bif.opcode    = t.op;
        bif.red_op_A  = t.ra;
        bif.red_op_B  = t.rb;
        bif.bypass_A  = t.ba;
        bif.bypass_B  = t.bb;
        bif.direction = t.dir;
        bif.serial_in = t.si;
        bif.shamt     = t.sh;
        bif.cin       = t.cin;
    endtask

    // Reference: the operation's effect, bit by bit for shifts and rotates.
    task automatic apply(tx_t t);
        int a, b, sel, v;
        a = sx(t.a);
        b = sx(t.b);
        if (t.op > 5 || ((t.ra || t.rb) && t.op > 1)) begin
            m_out  = 0;
            m_leds = ~m_leds & MASK;
            if (m_err < EMAX) m_err++;
            return;
        end
        m_leds = 0;
        if (t.ba || t.bb) begin
            m_out = (t.ba && (!t.bb || PRI != 0)) ? int'(t.a) : int'(t.b);
            return;
        end
        sel = (t.ra && (!t.rb || PRI != 0)) ? int'(t.a) : int'(t.b);
        v   = m_out;
        case (t.op)
            0: v = (t.ra || t.rb) ? int'(sel != 0) : int'(t.a | t.b);
            1: v = (t.ra || t.rb) ? ($countones(sel) % 2) : int'(t.a ^ t.b);
            2: v = (a + b + (FULL != 0 ? int'(t.cin) : 0)) & MASK;
            3: v = (a * b) & MASK;
            4: for (int k = 0; k < int'(t.sh); k++)
                   v = t.dir ? (((v << 1) | int'(t.si)) & MASK)
                             : ((v >> 1) | (int'(t.si) << (OUT_W - 1)));
            default: for (int k = 0; k < int'(t.sh) % OUT_W; k++)
                   v = t.dir ? (((v << 1) | (v >> (OUT_W - 1))) & MASK)
                             : ((v >> 1) | ((v & 1) << (OUT_W - 1)));
        endcase
        m_out = v;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out",       32'(bif.out),       32'(m_out));
        chk("out_valid", 32'(bif.out_valid), 32'(m_ov));
        chk("leds",      32'(bif.leds),      32'(m_leds));
        chk("err_cnt",   32'(bif.err_cnt),   32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        m_ov = int'(s1.v);
        if (s1.v) apply(s1);
        s1 = cur;
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m_out = 0; m_leds = 0; m_err = 0; m_ov = 0;
        s1 = '{default: 0};
    endtask

    initial begin
        tx_t t;
        rst_n = 1'b0;
        model_reset();
        drive(mk(0, 0, 0, 0));
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry-in
        t = mk(1, 2, 3'b011, 3'b111); t.cin = 1'b1;
        drive(t); tick();
        drive(mk(0, 0, 0, 0)); tick();
        chk("add_const", 32'(bif.out), (FULL != 0) ? 32'd3 : 32'd2);

        // MULT -4 * 3
        drive(mk(1, 3, 3'b100, 3'b011)); tick();
        drive(mk(0, 0, 0, 0)); tick();
        chk("mult_const", 32'(bif.out), 32'b110100);

        // Three consecutive invalid operations
        drive(mk(1, 6, 1, 2)); tick();
        drive(mk(1, 6, 1, 2)); tick();
        chk("inv1_leds", 32'(bif.leds), 32'h3F);
        drive(mk(1, 6, 1, 2)); tick();
        chk("inv2_leds", 32'(bif.leds), 32'h00);
        drive(mk(0, 0, 0, 0)); tick();
        chk("inv3_leds", 32'(bif.leds), 32'h3F);
        chk("inv3_err",  32'(bif.err_cnt), 32'd3);

        // Bypass tie, then chained SHIFT and ROTATE
        t = mk(1, 0, 3'b101, 3'b010); t.ba = 1'b1; t.bb = 1'b1;
        drive(t); tick();
        t = mk(1, 4, 0, 0); t.dir = 1'b1; t.sh = 3'd2; t.si = 1'b1;
        drive(t); tick();
        chk("bypass_const", 32'(bif.out), 32'b000101);
        t = mk(1, 5, 0, 0); t.dir = 1'b0; t.sh = 3'd1;
        drive(t); tick();
        chk("shift_const", 32'(bif.out), 32'b010111);
        drive(mk(0, 0, 0, 0)); tick();
        chk("rotate_const", 32'(bif.out), 32'b101011);
        drive(mk(0, 0, 0, 0)); tick();

        // Shift by an over-range amount fills with serial_in
        t = mk(1, 4, 0, 0); t.sh = 3'd7; t.si = 1'b1;
        drive(t); tick();
        drive(mk(0, 0, 0, 0)); tick();
        chk("shift_fill", 32'(bif.out), 32'h3F);

        for (int i = 0; i < 300; i++) begin
            drive(rnd()); tick();
        end

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(mk(1, 7, 0, 0)); tick();
        end
        chk("err_sat", 32'(bif.err_cnt), 32'(EMAX));
        drive(mk(1, 7, 0, 0)); tick();
        drive(mk(0, 0, 0, 0)); tick();

        for (int i = 0; i < 300; i++) begin
            drive(rnd()); tick();
        end

        // Asynchronous reset between edges
        drive(rnd());
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(rnd()); tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
